fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised operand-bypass and load-use hazard unit for the pipelined core. It holds a shift-register scoreboard of every in-flight register writer from EX through the last tracked post-EX stage, including each writer's result data. From that it drives forwarding selects and data for any number of EX-stage source operands. It also raises the ID-stage stall for load-use hazards when load data returns later than MEM/WB.

## Interface
Parameters:
- XLEN, 32: data width.
- NSRC, 2: number of source operands per instruction (1..4).
- DEPTH, 3: post-EX stages tracked (stage 1 = EX/MEM … stage DEPTH = last stage before the RF write is visible to ID reads); DEPTH >= 2.
- LOAD_STAGE, 2: first stage index at which load data exists; 2 <= LOAD_STAGE <= DEPTH.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  global freeze (e.g. memory wait); scoreboard does not shift.
- flush  in  1  discard the instruction leaving ID this cycle (branch redirect).
- id_valid  in  1  valid instruction in ID.
- id_rd  in  5  ID destination register.
- id_we  in  1  ID writes a register.
- id_is_load  in  1  ID instruction is a load.
- id_rs  in  5*NSRC  ID source registers, packed with operand 0 in the LSBs.
- id_rs_used  in  NSRC  per-operand "actually read" mask.
- ex_rs  in  5*NSRC  EX source registers.
- ex_result  in  XLEN  ALU result of the instruction currently in EX.
- load_data  in  XLEN  load data for the entry currently at stage LOAD_STAGE-1.
- stall  out  1  hold PC/IF/ID and inject a bubble into EX.
- fw_sel  out  NSRC  per-operand "use fw_data instead of RF data".
- fw_data  out  XLEN*NSRC  forwarded operand values.
- fw_miss  out  1  an EX operand's youngest producer has no data yet (verification flag; must never assert).

## Operation
- Entry fields: valid, rd, we, is_load, ready, data. Stage 0 is the instruction in EX and holds no data. Stages 1..DEPTH hold results.
- Advance: every cycle with hold=0.
- On advance, stage 0 is loaded from ID. It receives a bubble (valid=0) if stall, flush or !id_valid.
- On advance, stage k receives stage k-1 for k >= 1.
- Stage 1 data <= ex_result, ready <= !is_load.
- Stage LOAD_STAGE: if the entry is a load, data <= load_data and ready <= 1.
- Every other stage copies data and ready unchanged.
- Hit for entry at stage k against register r: valid && we && rd != 0 && rd == r.
- Forwarding, per EX operand i: search stages 1..DEPTH; the youngest hit (lowest k) wins.
  - If that hit is ready: fw_sel[i]=1 and fw_data[i]=data.
  - If it is not ready: fw_sel[i]=0 and fw_miss=1.
  - No hit, or ex_rs[i]=0: fw_sel[i]=0 and fw_data[i]=0.
- Stall: asserted when id_valid and some operand i with id_rs_used[i] and id_rs[i] != 0 hits an entry at stage k (0..DEPTH-1) that is a load with k+1 < LOAD_STAGE.
  - The youngest hit governs. A younger non-load hit masks an older load.
  - With the default LOAD_STAGE=2, only a load in EX stalls, for exactly 1 cycle.
  - With LOAD_STAGE=L, a load immediately ahead of its consumer stalls it L-1 cycles.
- hold=1: no state change. stall and fw_* are still evaluated combinationally from the frozen state.
- flush and stall in the same cycle: a bubble is injected either way.

## Timing
- Reset: all entries valid=0, ready=0, data=0. Consequently stall=0, fw_sel=0, fw_data=0 and fw_miss=0 until the first advance.
- stall, fw_sel, fw_data and fw_miss are combinational from the current state and inputs: zero latency, no internal pipeline.
- A result is forwardable the cycle after its producer leaves EX. It remains forwardable for DEPTH cycles of advance, then drops out.
- Load data is forwardable from the cycle the load occupies stage LOAD_STAGE.
- rst_n asserted mid-operation clears all entries immediately (asynchronous). Outputs return to their reset values in the same cycle.
- Removal of rst_n is synchronous to clk.

## Test plan
- Back-to-back ALU hazard:
  - Stimulus: add x5 (ex_result=0x11) then sub using rs1=x5.
  - Response: fw_sel[0]=1, fw_data[0]=0x11, stall=0.
- Two producers of the same register:
  - Stimulus: x7=0xA at stage 2 and x7=0xB at stage 1, consumer reads x7.
  - Response: fw_data=0xB (youngest wins).
- Load-use, LOAD_STAGE=2:
  - Stimulus: lw x3 with a dependent add in ID.
  - Response: stall=1 for exactly 1 cycle. Next cycle the add is in EX with fw_sel=1 and fw_data=load_data (0xDEAD_BEEF). fw_miss=0 throughout.
- Load-use, LOAD_STAGE=3, DEPTH=4:
  - Stimulus: lw x3 then a dependent instruction.
  - Response: stall for 2 cycles.
  - Variant: with one independent instruction between them, the stall lasts 1 cycle.
- Register x0 and unused operands:
  - Stimulus: a producer writes rd=x0; a consumer has rs1=x0. Separately, a load hit occurs with id_rs_used=0.
  - Response: fw_sel=0 and stall=0 in both cases.
- hold, flush and reset:
  - hold=1 for 3 cycles: the fw_data and stall values are stable.
  - flush with stall=1: a bubble enters EX.
  - rst_n pulsed with 3 valid entries: fw_sel=0 immediately, and no forwarding occurs after release.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand-bypass and load-use hazard unit. A shift-register scoreboard follows
//   every in-flight register writer from EX (stage 0) through stage DEPTH, the
//   last stage before its register-file write becomes visible to ID reads.
//   Stages 1..DEPTH carry the writer's result. The scoreboard drives the
//   forwarding selects and data for the EX source operands. It also raises the
//   ID stall when a load's data would arrive too late for its consumer.
//
// Parameters
//   XLEN        data width
//   NSRC        source operands per instruction (1..4)
//   DEPTH       post-EX stages tracked (>= 2)
//   LOAD_STAGE  first stage holding load data (2..DEPTH)
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   hold              freeze: scoreboard does not shift
//   flush             discard the instruction leaving ID this cycle
//   id_valid/rd/we/is_load, id_rs, id_rs_used
//                     instruction in ID, its sources and per-operand read mask
//   ex_rs             sources of the instruction in EX (operand 0 in the LSBs)
//   ex_result         ALU result of the instruction in EX
//   load_data         load data for the entry at stage LOAD_STAGE-1
//   stall             hold PC/IF/ID and inject a bubble into EX
//   fw_sel, fw_data   per-operand bypass select and bypass value
//   fw_miss           youngest producer of an EX operand has no data yet
module fwd_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [4:0]           id_rd,
  input  logic                 id_we,
  input  logic                 id_is_load,
  input  logic [5*NSRC-1:0]    id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [5*NSRC-1:0]    ex_rs,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [XLEN-1:0]      load_data,
  output logic                 stall,
  output logic [NSRC-1:0]      fw_sel,
  output logic [XLEN*NSRC-1:0] fw_data,
  output logic                 fw_miss
);

  logic [DEPTH:0]   r_valid;
  logic [DEPTH:0]   r_we;
  logic [4:0]       r_rd [0:DEPTH];
  // The load flag only matters before the load stage and for stall lookup,
  // which never looks at stage DEPTH, so it is not carried there.
  logic [DEPTH-1:0] r_load;
  logic [DEPTH:1]   r_ready;
  logic [XLEN-1:0]  r_data [1:DEPTH];

  logic             w_fw_found;
  logic             w_fw_ready;
  logic [XLEN-1:0]  w_fw_val;
  logic [4:0]       w_ex_rs;
  logic             w_st_found;
  logic             w_st_late;
  logic [4:0]       w_id_rs;

  function automatic logic f_hit(input logic v, input logic we,
                                 input logic [4:0] rd, input logic [4:0] rs);
    return v && we && (rd != 5'd0) && (rd == rs);
  endfunction

  // Forwarding: scan oldest to youngest so the youngest hit is left standing.
  always_comb begin
    fw_sel     = '0;
    fw_data    = '0;
    fw_miss    = 1'b0;
    w_fw_found = 1'b0;
    w_fw_ready = 1'b0;
    w_fw_val   = '0;
    w_ex_rs    = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_ex_rs    = ex_rs[i*5 +: 5];
      w_fw_found = 1'b0;
      w_fw_ready = 1'b0;
      w_fw_val   = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (f_hit(r_valid[k], r_we[k], r_rd[k], w_ex_rs)) begin
          w_fw_found = 1'b1;
          w_fw_ready = r_ready[k];
          w_fw_val   = r_data[k];
        end
      end
      if (w_fw_found && (w_ex_rs != 5'd0)) begin
        if (w_fw_ready) begin
          fw_sel[i]                 = 1'b1;
          fw_data[i*XLEN +: XLEN]   = w_fw_val;
        end else begin
          fw_miss = 1'b1;
        end
      end
    end
  end

  // Load-use stall: a load at stage k delivers its data when it reaches
  // LOAD_STAGE; the consumer would reach EX with the load at stage k+1.
  // A younger non-load writer of the same register hides the older load.
  always_comb begin
    stall      = 1'b0;
    w_st_found = 1'b0;
    w_st_late  = 1'b0;
    w_id_rs    = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_id_rs    = id_rs[i*5 +: 5];
      w_st_found = 1'b0;
      w_st_late  = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (f_hit(r_valid[k], r_we[k], r_rd[k], w_id_rs)) begin
          w_st_found = 1'b1;
          w_st_late  = r_load[k] && ((k + 1) < LOAD_STAGE);
        end
      end
      if (id_valid && id_rs_used[i] && (w_id_rs != 5'd0) && w_st_found && w_st_late)
        stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_we    <= '0;
      r_load  <= '0;
      r_ready <= '0;
      for (int k = 0; k <= DEPTH; k++) r_rd[k] <= '0;
      for (int k = 1; k <= DEPTH; k++) r_data[k] <= '0;
    end else if (!hold) begin
      r_valid[0] <= id_valid && !stall && !flush;
      r_we[0]    <= id_we;
      r_rd[0]    <= id_rd;
      r_load[0]  <= id_is_load;
      for (int k = 1; k <= DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      for (int k = 1; k < DEPTH; k++) r_load[k] <= r_load[k-1];
      r_data[1]  <= ex_result;
      r_ready[1] <= !r_load[0];
      for (int k = 2; k <= DEPTH; k++) begin
        if ((k == LOAD_STAGE) && r_load[k-1]) begin
          r_data[k]  <= load_data;
          r_ready[k] <= 1'b1;
        end else begin
          r_data[k]  <= r_data[k-1];
          r_ready[k] <= r_ready[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hold, flush, id_valid, id_we, id_is_load;
  logic [4:0]  id_rd;
  logic [9:0]  id_rs, ex_rs;
  logic [1:0]  id_rs_used;
  logic [31:0] ex_result, load_data;

  logic        a_stall, a_miss, b_stall, b_miss;
  logic [1:0]  a_sel, b_sel;
  logic [63:0] a_data, b_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_result(ex_result), .load_data(load_data),
    .stall(a_stall), .fw_sel(a_sel), .fw_data(a_data), .fw_miss(a_miss)
  );

  fwd_hazard_unit #(.DEPTH(4), .LOAD_STAGE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_result(ex_result), .load_data(load_data),
    .stall(b_stall), .fw_sel(b_sel), .fw_data(b_data), .fw_miss(b_miss)
  );

  // One cycle of stimulus plus the outputs expected while it is applied.
  typedef struct {
    logic        h, fl, idv, we, ld;
    logic [4:0]  rd, rs0, rs1;
    logic [1:0]  used;
    logic [4:0]  ex0, ex1;
    logic [31:0] exr, ldd;
    logic        es;
    logic [1:0]  esel;
    logic [31:0] ed0, ed1;
  } row_t;

  row_t sb[$];

  function automatic row_t mk(input int h, fl, idv, we, ld, rd, rs0, rs1, used, ex0, ex1,
                              input logic [31:0] exr, ldd, input int es, esel,
                              input logic [31:0] ed0, ed1);
    row_t r;
    r.h = 1'(h);     r.fl = 1'(fl);   r.idv = 1'(idv); r.we = 1'(we); r.ld = 1'(ld);
    r.rd = 5'(rd);   r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used);
    r.ex0 = 5'(ex0); r.ex1 = 5'(ex1); r.exr = exr;     r.ldd = ldd;
    r.es = 1'(es);   r.esel = 2'(esel); r.ed0 = ed0;   r.ed1 = ed1;
    return r;
  endfunction

  task automatic apply(input row_t r);
    hold = r.h; flush = r.fl; id_valid = r.idv; id_we = r.we; id_is_load = r.ld;
    id_rd = r.rd; id_rs = {r.rs1, r.rs0}; id_rs_used = r.used;
    ex_rs = {r.ex1, r.ex0}; ex_result = r.exr; load_data = r.ldd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(mk(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    // Busy-looking inputs: outputs must still be zero from the cleared state.
    apply(mk(0,0,1,1,1, 3,3,3,3, 3,3, 32'h55,32'h66, 0,0,0,0));
    #2;
    n_tests += 8;
    if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset a.stall: got %b want 0", a_stall); end
    if (a_sel   !== 2'b0) begin n_fail++; $display("FAIL reset a.fw_sel: got %b want 00", a_sel); end
    if (a_data  !== 64'b0) begin n_fail++; $display("FAIL reset a.fw_data: got %h want 0", a_data); end
    if (a_miss  !== 1'b0) begin n_fail++; $display("FAIL reset a.fw_miss: got %b want 0", a_miss); end
    if (b_stall !== 1'b0) begin n_fail++; $display("FAIL reset b.stall: got %b want 0", b_stall); end
    if (b_sel   !== 2'b0) begin n_fail++; $display("FAIL reset b.fw_sel: got %b want 00", b_sel); end
    if (b_data  !== 64'b0) begin n_fail++; $display("FAIL reset b.fw_data: got %h want 0", b_data); end
    if (b_miss  !== 1'b0) begin n_fail++; $display("FAIL reset b.fw_miss: got %b want 0", b_miss); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0,0,1,1,0, 5,0,0,0, 0,0, 0,0,         0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 8,5,6,3, 0,0, 32'h11,0,    0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 5,6, 32'h22,0,    0,1,32'h11,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 5,8, 0,0,         0,3,32'h11,32'h22));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 5,8, 0,0,         0,3,32'h11,32'h22));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 5,8, 0,0,         0,2,0,32'h22));
    do_reset();
    foreach (rows[j]) begin
      apply(rows[j]); sb.push_back(rows[j]); #1;
      e = sb.pop_front();
      n_tests += 4;
      if (a_stall !== e.es) begin n_fail++; $display("FAIL b2b[%0d] stall: got %b want %b", j, a_stall, e.es); end
      if (a_sel !== e.esel) begin n_fail++; $display("FAIL b2b[%0d] fw_sel: got %b want %b", j, a_sel, e.esel); end
      if (a_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL b2b[%0d] fw_data: got %h want %h", j, a_data, {e.ed1, e.ed0}); end
      if (a_miss !== 1'b0) begin n_fail++; $display("FAIL b2b[%0d] fw_miss: got %b want 0", j, a_miss); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_two_producers();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0,0,1,1,0, 7,0,0,0, 0,0, 0,0,      0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 7,0,0,0, 0,0, 32'hA,0,  0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 9,7,7,3, 0,0, 32'hB,0,  0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 7,7, 0,0,      0,3,32'hB,32'hB));
    do_reset();
    foreach (rows[j]) begin
      apply(rows[j]); sb.push_back(rows[j]); #1;
      e = sb.pop_front();
      n_tests += 4;
      if (a_stall !== e.es) begin n_fail++; $display("FAIL youngest[%0d] stall: got %b want %b", j, a_stall, e.es); end
      if (a_sel !== e.esel) begin n_fail++; $display("FAIL youngest[%0d] fw_sel: got %b want %b", j, a_sel, e.esel); end
      if (a_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL youngest[%0d] fw_data: got %h want %h", j, a_data, {e.ed1, e.ed0}); end
      if (a_miss !== 1'b0) begin n_fail++; $display("FAIL youngest[%0d] fw_miss: got %b want 0", j, a_miss); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use_l2();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0,0,1,1,1, 3,0,0,0, 0,0, 0,0,               0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 32'h100,0,         1,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 0,32'hDEADBEEF,    0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 3,0, 0,0,               0,1,32'hDEADBEEF,0));
    do_reset();
    foreach (rows[j]) begin
      apply(rows[j]); sb.push_back(rows[j]); #1;
      e = sb.pop_front();
      n_tests += 4;
      if (a_stall !== e.es) begin n_fail++; $display("FAIL lu2[%0d] stall: got %b want %b", j, a_stall, e.es); end
      if (a_sel !== e.esel) begin n_fail++; $display("FAIL lu2[%0d] fw_sel: got %b want %b", j, a_sel, e.esel); end
      if (a_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL lu2[%0d] fw_data: got %h want %h", j, a_data, {e.ed1, e.ed0}); end
      if (a_miss !== 1'b0) begin n_fail++; $display("FAIL lu2[%0d] fw_miss: got %b want 0", j, a_miss); end
      @(posedge clk); #1;
    end
  endtask

  // Checked on the DEPTH=4, LOAD_STAGE=3 instance.
  task automatic test_load_use_l3();
    row_t rows[$];
    row_t e;
    // load immediately ahead of consumer: 2 stall cycles
    rows.push_back(mk(0,0,1,1,1, 3,0,0,0, 0,0, 0,0,             0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 32'h200,0,       1,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 0,0,             1,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 0,32'hCAFEF00D,  0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 3,0, 0,0,             0,1,32'hCAFEF00D,0));
    // one independent instruction in between: 1 stall cycle
    rows.push_back(mk(0,0,1,1,1, 3,0,0,0, 0,0, 0,0,             0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 10,9,0,1, 0,0, 32'h300,0,      0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 32'h55,0,        1,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 0,32'h0BADF00D,  0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 3,0, 0,0,             0,1,32'h0BADF00D,0));
    // younger ALU write of the same register hides the older load
    rows.push_back(mk(0,0,1,1,1, 3,0,0,0, 0,0, 0,0,             0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 3,0,0,0, 0,0, 32'h400,0,       0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 4,3,0,1, 0,0, 32'h77,0,        0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 3,0, 0,0,             0,1,32'h77,0));
    foreach (rows[j]) begin
      if (j == 0 || j == 5 || j == 10) do_reset();
      apply(rows[j]); sb.push_back(rows[j]); #1;
      e = sb.pop_front();
      n_tests += 4;
      if (b_stall !== e.es) begin n_fail++; $display("FAIL lu3[%0d] stall: got %b want %b", j, b_stall, e.es); end
      if (b_sel !== e.esel) begin n_fail++; $display("FAIL lu3[%0d] fw_sel: got %b want %b", j, b_sel, e.esel); end
      if (b_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL lu3[%0d] fw_data: got %h want %h", j, b_data, {e.ed1, e.ed0}); end
      if (b_miss !== 1'b0) begin n_fail++; $display("FAIL lu3[%0d] fw_miss: got %b want 0", j, b_miss); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_unused();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0,0,1,1,0, 0,0,0,0, 0,0, 0,0,          0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 9,0,0,3, 0,0, 32'h55,0,     0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0, 32'h66,0,     0,0,0,0));
    rows.push_back(mk(0,0,1,1,1, 4,0,0,0, 0,0, 0,0,          0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 12,4,4,0, 0,0, 32'h300,0,   0,0,0,0));
    rows.push_back(mk(0,0,1,1,1, 11,0,0,0, 0,0, 0,0,         0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 12,0,11,2, 0,0, 0,0,        1,0,0,0));
    do_reset();
    foreach (rows[j]) begin
      apply(rows[j]); sb.push_back(rows[j]); #1;
      e = sb.pop_front();
      n_tests += 4;
      if (a_stall !== e.es) begin n_fail++; $display("FAIL x0[%0d] stall: got %b want %b", j, a_stall, e.es); end
      if (a_sel !== e.esel) begin n_fail++; $display("FAIL x0[%0d] fw_sel: got %b want %b", j, a_sel, e.esel); end
      if (a_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL x0[%0d] fw_data: got %h want %h", j, a_data, {e.ed1, e.ed0}); end
      if (a_miss !== 1'b0) begin n_fail++; $display("FAIL x0[%0d] fw_miss: got %b want 0", j, a_miss); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold_flush();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0,0,1,1,0, 5,0,0,0, 0,0, 0,0,          0,0,0,0));
    rows.push_back(mk(0,0,1,1,1, 6,0,0,0, 0,0, 32'h11,0,     0,0,0,0));
    for (int c = 0; c < 3; c++)
      rows.push_back(mk(1,0,1,1,0, 12,6,0,1, 5,0, 32'h99,0,  1,1,32'h11,0));
    rows.push_back(mk(0,1,1,1,0, 12,6,0,1, 5,0, 32'h99,0,    1,1,32'h11,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 12,12, 0,32'h1234, 0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 12,6, 0,0,         0,2,0,32'h1234));
    rows.push_back(mk(0,1,1,1,0, 13,0,0,0, 0,0, 0,0,         0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0, 32'h77,0,     0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 13,0, 0,0,         0,0,0,0));
    do_reset();
    foreach (rows[j]) begin
      apply(rows[j]); sb.push_back(rows[j]); #1;
      e = sb.pop_front();
      n_tests += 4;
      if (a_stall !== e.es) begin n_fail++; $display("FAIL holdflush[%0d] stall: got %b want %b", j, a_stall, e.es); end
      if (a_sel !== e.esel) begin n_fail++; $display("FAIL holdflush[%0d] fw_sel: got %b want %b", j, a_sel, e.esel); end
      if (a_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL holdflush[%0d] fw_data: got %h want %h", j, a_data, {e.ed1, e.ed0}); end
      if (a_miss !== 1'b0) begin n_fail++; $display("FAIL holdflush[%0d] fw_miss: got %b want 0", j, a_miss); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0,0,1,1,0, 5,0,0,0, 0,0, 0,0, 0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 6,0,0,0, 0,0, 1,0, 0,0,0,0));
    rows.push_back(mk(0,0,1,1,0, 7,0,0,0, 0,0, 2,0, 0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0, 3,0, 0,0,0,0));
    do_reset();
    foreach (rows[j]) begin
      apply(rows[j]); sb.push_back(rows[j]); #1;
      e = sb.pop_front();
      n_tests += 2;
      if (a_sel !== e.esel) begin n_fail++; $display("FAIL arst_fill[%0d] fw_sel: got %b want %b", j, a_sel, e.esel); end
      if (a_stall !== e.es) begin n_fail++; $display("FAIL arst_fill[%0d] stall: got %b want %b", j, a_stall, e.es); end
      @(posedge clk); #1;
    end
    // three valid entries now at stages 1..3: x7=3, x6=2, x5=1
    sb.push_back(mk(0,0,0,0,0, 0,0,0,0, 5,6, 0,0, 0,3,1,2));
    apply(sb[0]); #1;
    e = sb.pop_front();
    n_tests += 2;
    if (a_sel !== e.esel) begin n_fail++; $display("FAIL arst_pre fw_sel: got %b want %b", a_sel, e.esel); end
    if (a_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL arst_pre fw_data: got %h want %h", a_data, {e.ed1, e.ed0}); end
    rst_n = 1'b0;
    #1;
    n_tests += 3;
    if (a_sel !== 2'b00) begin n_fail++; $display("FAIL arst_now fw_sel: got %b want 00", a_sel); end
    if (a_data !== 64'b0) begin n_fail++; $display("FAIL arst_now fw_data: got %h want 0", a_data); end
    if (a_miss !== 1'b0) begin n_fail++; $display("FAIL arst_now fw_miss: got %b want 0", a_miss); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(mk(0,0,0,0,0, 0,0,0,0, 5,7, 0,0, 0,0,0,0));
    apply(sb[0]); #1;
    e = sb.pop_front();
    n_tests += 2;
    if (a_sel !== e.esel) begin n_fail++; $display("FAIL arst_post fw_sel: got %b want %b", a_sel, e.esel); end
    if (a_data !== {e.ed1, e.ed0}) begin n_fail++; $display("FAIL arst_post fw_data: got %h want %h", a_data, {e.ed1, e.ed0}); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_two_producers();
    test_load_use_l2();
    test_load_use_l3();
    test_x0_unused();
    test_hold_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
